// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Time-multiplexes DIGITS active-low segment patterns (bit 7 = dot) onto a
//   shared segment bus with one-hot active-low digit selects. All inputs are
//   snapshotted once per frame, and each digit slot opens with a blanking
//   interval to suppress ghosting.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           scan enable; 0 blanks the display and holds the scan at frame start
//   segs_in      DIGITS x 8-bit active-low patterns, digit i at [8i+7:8i]
//   seg_out      active-low segment/dot bus
//   dig_out      active-low digit selects, at most one low
//   frame_start  one-cycle pulse on the first cycle of each frame
module seg_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [8*DIGITS-1:0]   segs_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_out,
  output logic                  frame_start
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [8*DIGITS-1:0]   r_buf;

  logic [CW-1:0]         w_cnt_n;
  logic [IW-1:0]         w_idx_n;
  logic [8*DIGITS-1:0]   w_buf_n;
  logic                  w_wrap;
  logic                  w_lit;
  logic [7:0]            w_seg_n;
  logic [DIGITS-1:0]     w_dig_n;

  always_comb begin
    w_wrap  = en && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
    w_cnt_n = r_cnt;
    w_idx_n = r_idx;
    w_buf_n = r_buf;

    if (!en) begin
      w_cnt_n = '0;
      w_idx_n = '0;
      w_buf_n = segs_in;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_n = '0;
      w_idx_n = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      if (w_wrap) begin
        w_buf_n = segs_in;
      end
    end else begin
      w_cnt_n = r_cnt + 1'b1;
    end

    // Outputs are derived from next-state values so the registered outputs
    // line up with the (cnt, idx) they describe.
    w_lit   = en && (w_cnt_n >= CNT_BLANK);
    w_seg_n = '1;
    w_dig_n = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_lit && (w_idx_n == IW'(i))) begin
        w_dig_n[i] = 1'b0;
        w_seg_n    = w_buf_n[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_buf       <= '1;
      seg_out     <= '1;
      dig_out     <= '1;
      frame_start <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_buf       <= w_buf_n;
      seg_out     <= w_seg_n;
      dig_out     <= w_dig_n;
      frame_start <= w_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] segs0 = '1;
  logic [47:0] segs1 = '1;

  logic [7:0]  seg0, seg1;
  logic [3:0]  dig0;
  logic [5:0]  dig1;
  logic        fs0, fs1;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .segs_in(segs0),
    .seg_out(seg0), .dig_out(dig0), .frame_start(fs0));

  seg_scan_mux #(.DIGITS(6), .PRESCALE(4), .BLANK_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .segs_in(segs1),
    .seg_out(seg1), .dig_out(dig1), .frame_start(fs1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a flat position within the frame (count of enabled
  // edges since scan start, modulo frame length) plus the snapshot buffer.
  int          MD[2] = '{4, 6};
  int          MP[2] = '{8, 4};
  int          MB[2] = '{2, 1};
  int          mpos[2];
  bit          mrun[2];
  bit          mfs[2];
  logic [47:0] mbuf[2];

  int  last_lit[2];
  int  blank_run[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpos[k] = 0; mrun[k] = 1'b0; mfs[k] = 1'b0; mbuf[k] = '1;
    end
  endtask

  task automatic model_adv(input int k, input bit e, input logic [47:0] s);
    if (!e) begin
      mpos[k] = 0; mrun[k] = 1'b0; mfs[k] = 1'b0; mbuf[k] = s;
    end else begin
      mpos[k] = (mpos[k] + 1) % (MD[k] * MP[k]);
      mrun[k] = 1'b1;
      mfs[k]  = (mpos[k] == 0);
      if (mpos[k] == 0) mbuf[k] = s;
    end
  endtask

  function automatic bit exp_lit(input int k);
    return mrun[k] && ((mpos[k] % MP[k]) >= MB[k]);
  endfunction

  function automatic logic [5:0] exp_dig(input int k);
    logic [5:0] d;
    d = '1;
    if (exp_lit(k)) d[mpos[k] / MP[k]] = 1'b0;
    return d;
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    logic [47:0] b;
    b = mbuf[k];
    if (!exp_lit(k)) return 8'hFF;
    return b[8*(mpos[k] / MP[k]) +: 8];
  endfunction

  task automatic invariants(input int k, input logic [5:0] d, input logic [7:0] s);
    int lit;
    check("dig_onehot", 64'($countones(~d) <= 1), 64'd1);
    if (d == 6'h3F) begin
      check("blank_seg", 64'(s), 64'hFF);
      blank_run[k]++;
    end else begin
      lit = 0;
      for (int i = 0; i < 6; i++) if (!d[i]) lit = i;
      if (last_lit[k] >= 0 && lit != last_lit[k])
        check("blank_gap", 64'(blank_run[k] >= MB[k]), 64'd1);
      last_lit[k]  = lit;
      blank_run[k] = 0;
    end
  endtask

  task automatic check_outs();
    check("seg0", 64'(seg0), 64'(exp_seg(0)));
    check("dig0", 64'({2'b11, dig0}), 64'(exp_dig(0)));
    check("fs0",  64'(fs0), 64'(mfs[0]));
    check("seg1", 64'(seg1), 64'(exp_seg(1)));
    check("dig1", 64'(dig1), 64'(exp_dig(1)));
    check("fs1",  64'(fs1), 64'(mfs[1]));
    invariants(0, {2'b11, dig0}, seg0);
    invariants(1, dig1, seg1);
  endtask

  // Called at a negedge: apply inputs, predict the next edge, check after it.
  task automatic step(input bit e, input logic [31:0] s0, input logic [47:0] s1);
    en = e; segs0 = s0; segs1 = s1;
    if (!rst) begin
      model_adv(0, e, {16'hFFFF, s0});
      model_adv(1, e, s1);
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  initial begin
    logic [31:0] r0;
    logic [47:0] r1;
    int guard;

    last_lit  = '{-1, -1};
    blank_run = '{0, 0};
    model_reset();

    // Power-on reset, then check reset state.
    @(negedge clk);
    step(1'b0, segs0, segs1);
    check_outs();
    rst = 1'b0;

    // First frame after reset shows the all-ones buffer.
    r0 = $urandom; r1 = rnd48();
    for (int i = 0; i < 40; i++) step(1'b1, r0, r1);

    // Snapshot while disabled, then scan a known pattern; segs_in keeps
    // changing mid-frame and must only show up after the next snapshot.
    for (int i = 0; i < 3; i++) step(1'b0, 32'hF9A4B0C0, 48'h1234F9A4B0C0);
    for (int i = 0; i < 70; i++) begin
      if (i % 5 == 0) begin r0 = $urandom; r1 = rnd48(); end
      step(1'b1, (i < 12) ? 32'hF9A4B0C0 : ((i < 40) ? 32'h80808080 : r0), r1);
    end

    // Drop en while digit 2 is lit, then re-raise it.
    guard = 0;
    while (!(exp_lit(0) && mpos[0] / MP[0] == 2) && guard < 100) begin
      step(1'b1, $urandom, rnd48());
      guard++;
    end
    check("reach_idx2", 64'(guard < 100), 64'd1);
    r0 = $urandom; r1 = rnd48();
    for (int i = 0; i < 4; i++) step(1'b0, r0, r1);
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, rnd48());

    // Asynchronous reset while a digit is lit.
    guard = 0;
    while (!exp_lit(0) && guard < 20) begin
      step(1'b1, $urandom, rnd48());
      guard++;
    end
    check("reach_lit", 64'(guard < 20), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_seg0", 64'(seg0), 64'hFF);
    check("rst_async_dig0", 64'(dig0), 64'hF);
    check("rst_async_seg1", 64'(seg1), 64'hFF);
    check("rst_async_dig1", 64'(dig1), 64'h3F);
    model_reset();
    @(negedge clk);
    step(1'b1, $urandom, rnd48());
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, rnd48());

    // Long randomized run: occasional enable drops and input changes.
    r0 = $urandom; r1 = rnd48();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(7, 0) == 0) begin r0 = $urandom; r1 = rnd48(); end
      step($urandom_range(49, 0) != 0, r0, r1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
